// File: rtl/instr_enc_pkg.sv
// Shared constants for the RV64 load/store/branch instruction encoder.
package instr_enc_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned IMM_W   = 64;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        FMT_LOAD   = 2'd0,
        FMT_STORE  = 2'd1,
        FMT_BRANCH = 2'd2,
        FMT_RSVD   = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_RANGE = 2'd1,
        ERR_FMT   = 2'd2
    } err_e;

    // True when the 64-bit immediate is a sign extension of its low 12 bits.
    function automatic logic imm_fits12(input logic [IMM_W-1:0] imm);
        return (&imm[IMM_W-1:11]) || !(|imm[IMM_W-1:11]);
    endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Synchronous FIFO with registered occupancy; caller never pushes when full
// or pops when empty.
module sync_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/instr_encoder.sv
// Packs format, registers, funct3 and a sign-extended immediate into an RV64
// load/store/branch word, queued through a small output FIFO.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_fmt,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [63:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             err_valid,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    fmt_e               fmt;
    logic               imm_ok;
    logic               bad_fmt;
    logic               accept;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [INSTR_W-1:0] word_c;

    assign fmt     = fmt_e'(in_fmt);
    assign imm_ok  = imm_fits12(in_imm);
    assign bad_fmt = (fmt == FMT_RSVD);
    assign accept  = in_valid && in_ready;
    assign push    = accept && !bad_fmt && imm_ok;
    assign pop     = out_valid && out_ready;

    // Branch immediates arrive in halfword units, so bit 0 of the byte offset is implicit.
    always_comb begin
        word_c = '0;
        case (fmt)
            FMT_LOAD:   word_c = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD};
            FMT_STORE:  word_c = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                                  in_imm[4:0], OPC_STORE};
            FMT_BRANCH: word_c = {in_imm[11], in_imm[9:4], in_rs2, in_rs1, in_funct3,
                                  in_imm[3:0], in_imm[10], OPC_BRANCH};
            default:    word_c = '0;
        endcase
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (word_c),
        .rdata (out_instr),
        .full  (full),
        .empty (empty)
    );

    assign in_ready  = !full;
    assign out_valid = !empty;

    // Error reporting and counters; a reserved format outranks a range error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
            enc_count <= '0;
            err_count <= '0;
        end else begin
            err_valid <= 1'b0;
            if (accept && (bad_fmt || !imm_ok)) begin
                err_valid <= 1'b1;
                err_code  <= bad_fmt ? ERR_FMT : ERR_RANGE;
                if (err_count != '1) err_count <= err_count + CNT_W'(1);
            end
            if (pop) enc_count <= enc_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed steps then random traffic
// compared against an ISA-level reference model.
module tb_instr_encoder;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_fmt = '0;
    logic [4:0]       in_rd = '0;
    logic [4:0]       in_rs1 = '0;
    logic [4:0]       in_rs2 = '0;
    logic [2:0]       in_funct3 = '0;
    logic [63:0]      in_imm = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_instr;
    logic             err_valid;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] enc_count;
    logic [CNT_W-1:0] err_count;

    instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .err_valid(err_valid), .err_code(err_code),
        .enc_count(enc_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] q[$];
    int          m_enc;
    int          m_err;
    logic        m_errv;
    logic [1:0]  m_errc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference encoding from the ISA view: byte offsets and field positions.
    function automatic logic [31:0] ref_encode(input logic [1:0] fmt, input logic [4:0] rd,
                                               input logic [4:0] rs1, input logic [4:0] rs2,
                                               input logic [2:0] f3, input longint imm);
        logic [63:0] w;
        longint      b;
        w = (64'(rs1) << 15) | (64'(f3) << 12);
        case (fmt)
            2'd0: w = w | ((imm & 64'hFFF) << 20) | (64'(rd) << 7) | 64'h03;
            2'd1: w = w | (((imm >> 5) & 64'h7F) << 25) | (64'(rs2) << 20)
                        | ((imm & 64'h1F) << 7) | 64'h23;
            default: begin
                b = imm * 2;
                w = w | (((b >> 12) & 1) << 31) | (((b >> 5) & 64'h3F) << 25)
                      | (64'(rs2) << 20) | (((b >> 1) & 64'hF) << 8)
                      | (((b >> 11) & 1) << 7) | 64'h63;
            end
        endcase
        return w[31:0];
    endfunction

    function automatic longint dec_s(input logic [31:0] w);
        logic signed [11:0] f;
        longint v;
        f = {w[31:25], w[11:7]};
        v = f;
        return v;
    endfunction

    function automatic longint dec_b(input logic [31:0] w);
        logic signed [12:0] f;
        longint v;
        f = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        v = f;
        return v >>> 1;
    endfunction

    task automatic model_reset();
        q.delete();
        m_enc  = 0;
        m_err  = 0;
        m_errv = 1'b0;
        m_errc = 2'd0;
    endtask

    task automatic check_all();
        chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() != DEPTH});
        chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
        if (q.size() != 0) chk("out_instr", {32'd0, out_instr}, {32'd0, q[0]});
        chk("err_valid", {63'd0, err_valid}, {63'd0, m_errv});
        chk("err_code", {62'd0, err_code}, {62'd0, m_errc});
        chk("enc_count", {48'd0, enc_count}, 64'(m_enc));
        chk("err_count", {48'd0, err_count}, 64'(m_err));
    endtask

    // One clock: predict from pre-edge inputs, advance, compare.
    task automatic cyc();
        logic        acc, pp;
        logic [31:0] w;
        longint      simm;
        acc  = in_valid && (q.size() != DEPTH);
        pp   = (q.size() != 0) && out_ready;
        simm = $signed(in_imm);
        w    = ref_encode(in_fmt, in_rd, in_rs1, in_rs2, in_funct3, simm);
        @(posedge clk);
        #1;
        if (pp) begin
            void'(q.pop_front());
            m_enc = (m_enc + 1) % 65536;
        end
        m_errv = 1'b0;
        if (acc) begin
            if (in_fmt == 2'd3 || simm < -2048 || simm > 2047) begin
                m_errv = 1'b1;
                m_errc = (in_fmt == 2'd3) ? 2'd2 : 2'd1;
                if (m_err < 65535) m_err++;
            end else begin
                q.push_back(w);
            end
        end
        check_all();
    endtask

    task automatic set_req(input logic [1:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input longint imm);
        in_valid  = 1'b1;
        in_fmt    = f;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_imm    = imm;
    endtask

    function automatic longint rand_imm();
        case ($urandom_range(0, 9))
            0: return 2047;
            1: return -2048;
            2: return 2048;
            3: return -2049;
            4: return longint'({$urandom, $urandom});
            default: return longint'($urandom_range(0, 4095)) - 2048;
        endcase
    endfunction

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
        chk("rst_err_valid", {63'd0, err_valid}, 64'd0);
        chk("rst_err_code", {62'd0, err_code}, 64'd0);
        chk("rst_enc_count", {48'd0, enc_count}, 64'd0);
        chk("rst_err_count", {48'd0, err_count}, 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {63'd0, in_ready}, 64'd1);

        // Single LOAD, visible one cycle after accept, counted on pop.
        out_ready = 1'b1;
        set_req(2'd0, 5'd5, 5'd2, 5'd0, 3'd3, -8);
        cyc();
        chk("load_word", {32'd0, out_instr}, 64'hFF81_3283);
        in_valid = 1'b0;
        cyc();
        chk("enc_after_pop", {48'd0, enc_count}, 64'd1);

        // STORE then BRANCH, with round-trip decode of both immediates.
        out_ready = 1'b0;
        set_req(2'd1, 5'd0, 5'd2, 5'd8, 3'd3, 16);
        cyc();
        chk("store_word", {32'd0, out_instr}, 64'h0081_3823);
        chk("store_rt", 64'(dec_s(out_instr)), 64'd16);
        out_ready = 1'b1;
        set_req(2'd2, 5'd0, 5'd1, 5'd2, 3'd0, -2);
        cyc();
        chk("branch_word", {32'd0, out_instr}, 64'hFE20_8EE3);
        chk("branch_rt", 64'(dec_b(out_instr)), 64'(-2));
        in_valid = 1'b0;
        cyc();

        // Range error, then reserved format (with and without a range error).
        set_req(2'd0, 5'd1, 5'd1, 5'd1, 3'd0, 2048);
        cyc();
        chk("range_err_valid", {63'd0, err_valid}, 64'd1);
        chk("range_err_code", {62'd0, err_code}, 64'd1);
        chk("range_err_count", {48'd0, err_count}, 64'd1);
        chk("range_no_word", {63'd0, out_valid}, 64'd0);
        in_valid = 1'b0;
        cyc();
        chk("err_pulse_one", {63'd0, err_valid}, 64'd0);
        chk("err_code_held", {62'd0, err_code}, 64'd1);
        set_req(2'd3, 5'd1, 5'd1, 5'd1, 3'd0, 0);
        cyc();
        chk("fmt_err_code", {62'd0, err_code}, 64'd2);
        chk("fmt_err_count", {48'd0, err_count}, 64'd2);
        set_req(2'd3, 5'd1, 5'd1, 5'd1, 3'd0, 5000);
        cyc();
        chk("fmt_precedence", {62'd0, err_code}, 64'd2);
        in_valid = 1'b0;
        cyc();

        // Backpressure: third request held until occupancy drops; no bypass when full.
        out_ready = 1'b0;
        set_req(2'd0, 5'd1, 5'd3, 5'd0, 3'd0, 1);
        cyc();
        set_req(2'd1, 5'd0, 5'd4, 5'd5, 3'd2, -100);
        cyc();
        chk("full_not_ready", {63'd0, in_ready}, 64'd0);
        set_req(2'd2, 5'd0, 5'd6, 5'd7, 3'd1, 300);
        cyc();
        cyc();
        out_ready = 1'b1;
        cyc();
        chk("no_bypass_ready", {63'd0, in_ready}, 64'd1);
        chk("order_second", {32'd0, out_instr}, 64'(ref_encode(2'd1, 5'd0, 5'd4, 5'd5, 3'd2, -100)));
        cyc();
        chk("order_third", {32'd0, out_instr}, 64'(ref_encode(2'd2, 5'd0, 5'd6, 5'd7, 3'd1, 300)));
        in_valid = 1'b0;
        cyc();

        // Steady push/pop at occupancy one.
        set_req(2'd0, 5'd9, 5'd10, 5'd0, 3'd4, 7);
        cyc();
        for (int i = 0; i < 6; i++) begin
            set_req(2'd0, 5'(i), 5'(i + 1), 5'd0, 3'(i), longint'(i * 37 - 100));
            cyc();
            chk("steady_valid", {63'd0, out_valid}, 64'd1);
        end
        in_valid = 1'b0;
        cyc();

        // Asynchronous reset with two words queued.
        out_ready = 1'b0;
        set_req(2'd0, 5'd1, 5'd1, 5'd0, 3'd0, 11);
        cyc();
        cyc();
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_enc_count", {48'd0, enc_count}, 64'd0);
        chk("arst_err_count", {48'd0, err_count}, 64'd0);
        chk("arst_out_instr", {32'd0, out_instr}, 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_all();
        out_ready = 1'b1;
        set_req(2'd0, 5'd5, 5'd2, 5'd0, 3'd3, -8);
        cyc();
        chk("post_rst_load", {32'd0, out_instr}, 64'hFF81_3283);
        in_valid = 1'b0;
        cyc();

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_fmt    = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            in_rd     = 5'($urandom);
            in_rs1    = 5'($urandom);
            in_rs2    = 5'($urandom);
            in_funct3 = 3'($urandom);
            in_imm    = rand_imm();
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming encoder that is the inverse of the pipeline's immediate extraction. It packs format, register fields, funct3 and a 64-bit sign-extended immediate into a 32-bit RV64 instruction word.
- Supported formats: load (I), store (S), branch (SB).
- Feeds the instruction-memory loader and the self-test sequencer through a small output FIFO with valid/ready handshakes on both sides.
- Out-of-range immediates are rejected and counted, never silently truncated.

Parameters:
- DEPTH, 2, output FIFO entries (power of two, >=2)
- CNT_W, 16, width of enc_count and err_count

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request this cycle
- in_fmt  in  2  0=LOAD, 1=STORE, 2=BRANCH, 3=reserved
- in_rd  in  5  destination register (LOAD only)
- in_rs1  in  5  source/base register
- in_rs2  in  5  second source (STORE, BRANCH)
- in_funct3  in  3  funct3 field
- in_imm  in  64  sign-extended immediate; BRANCH value is in halfword units (byte offset >>1)
- out_valid  out  1  out_instr holds a valid word
- out_ready  in  1  consumer accepts the word
- out_instr  out  32  encoded instruction (FIFO head)
- err_valid  out  1  one-cycle pulse: the previous accepted request was rejected
- err_code  out  2  0=none, 1=immediate range, 2=reserved format
- enc_count  out  CNT_W  instructions emitted, wraps
- err_count  out  CNT_W  rejected requests, saturates at all-ones

Behaviour:
- Reset (async, any cycle, mid-transfer included):
  - FIFO empty; out_valid=0, out_instr=0.
  - err_valid=0, err_code=0.
  - enc_count=0, err_count=0.
  - in_ready=1 on the first cycle after rst deasserts.
- Accept:
  - A request is accepted on a clk edge with in_valid && in_ready.
  - in_ready = (occupancy != DEPTH), taken from registered occupancy only.
  - No bypass: when full, in_ready=0 even if a pop happens the same cycle.
- Range check:
  - Legal only if in_imm[63:11] are all equal, i.e. signed 12-bit, -2048..2047.
  - Applies identically to all three formats.
- Encoding (combinational on the accepted request, written to FIFO at the accept edge):
  - LOAD: {imm[11:0], rs1, funct3, rd, 7'b0000011}; rs2 ignored.
  - STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011}; rd ignored.
  - BRANCH:
    - bit31=imm[11], bits30:25=imm[9:4], bits11:8=imm[3:0], bit7=imm[10]
    - bits24:20=rs2, bits19:15=rs1, bits14:12=funct3, bits6:0=7'b1100011; rd ignored.
  - Round-trip rule: decoding the word with the pipeline's immediate extraction returns in_imm exactly.
- Latency: request accepted at edge N -> out_valid=1 after edge N if the FIFO was empty. Order is strictly FIFO.
- Output handshake:
  - A pop occurs on an edge with out_valid && out_ready.
  - out_instr stays stable while out_valid && !out_ready.
  - Simultaneous push and pop leaves occupancy unchanged.
  - Pointers wrap modulo DEPTH.
- Error path:
  - A rejected request (range error, or fmt=3) is consumed but not written.
  - err_valid=1 for exactly the following cycle. err_code is held until the next error or reset.
  - err_count increments, saturating. fmt=3 takes precedence over a range error (code 2).
- enc_count increments on each pop, not on each push.

Decomposition:
- Shared package instr_enc_pkg holds:
  - opcode constants OPC_LOAD=7'b0000011, OPC_STORE=7'b0100011, OPC_BRANCH=7'b1100011
  - fmt encodings
  - err_code encodings
- One sub-module: sync_fifo (DEPTH, WIDTH=32) with registered occupancy, push/pop, full/empty.
- Packing and range check stay in instr_encoder.

Test Plan:
- LOAD rd=5, rs1=2, funct3=3, imm=-8 -> out_instr=0xFF813283 one cycle after accept; enc_count=1 after pop.
- STORE rs2=8, rs1=2, funct3=3, imm=16 -> out_instr=0x00813823; BRANCH rs1=1, rs2=2, funct3=0, imm=-2 -> 0xFE208EE3. Decoding both words gives back 16 and -2.
- LOAD imm=2048 -> no output word; err_valid pulses once with err_code=1; err_count=1. Then fmt=3 -> err_code=2, err_count=2.
- out_ready=0, push 3 requests (DEPTH=2) -> in_ready=0 after 2nd accept, 3rd held. Raise out_ready -> words emerge in order; 3rd accepted the cycle after occupancy drops.
- Full FIFO with out_ready=1 and in_valid=1 -> no push that cycle (no bypass), pop occurs. Steady push/pop at occupancy 1 sustains one word per cycle.
- Assert rst with 2 words queued and out_valid=1 -> immediately out_valid=0, counters 0; after release a fresh LOAD encodes correctly.
